// File: rtl/mtc_sl_frame_builder.sv
// mtc_sl_frame_builder
//   Builds the 193-bit MTC2SL word for one sector-logic link from one MTC
//   candidate per cycle and stamps the link trailer (t_reserved, CRC-8,
//   fiberid, slid, comma). Finished words sit in a show-ahead FIFO that
//   feeds the link serializer through a valid/ready handshake.
// Ports
//   clock, rst      system clock, synchronous active-high reset
//   cand_valid      candidate present this cycle (no upstream backpressure)
//   slc_header      SLC header word
//   slc_fields      SLC common fields; bits [39:0] carry the fields, [42:40] are not part of the word
//   slc_cointype    coincidence type
//   mdt_fields      MDT fields
//   mtc2sl          word at FIFO head (all-zero while mtc2sl_valid=0)
//   mtc2sl_valid    FIFO head valid
//   mtc2sl_ready    link takes the head word this cycle
//   drop_cnt        saturating count of candidates dropped for lack of room
//   fifo_level      current FIFO occupancy
// Word layout [192:0]
//   192 datavalid | 191:160 header | 159:120 slc fields | 119:117 cointype |
//   116:111 t_reserved | 110:103 crc | 102:99 fiberid | 98:93 slid |
//   92:85 comma | 84:49 mdt fields | 48:0 m_reserved
module mtc_sl_frame_builder #(
   parameter logic [5:0]  LINK_SLID    = 6'd0,
   parameter logic [3:0]  LINK_FIBERID = 4'd0,
   parameter logic [7:0]  COMMA        = 8'hBC,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic                          clock,
   input  logic                          rst,
   input  logic                          cand_valid,
   input  logic [31:0]                   slc_header,
   input  logic [42:0]                   slc_fields,
   input  logic [2:0]                    slc_cointype,
   input  logic [35:0]                   mdt_fields,
   output logic [192:0]                  mtc2sl,
   output logic                          mtc2sl_valid,
   input  logic                          mtc2sl_ready,
   output logic [15:0]                   drop_cnt,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned CW = AW + 2;

   // CRC-8, poly 0x07, init 0, MSB first, no reflection, no final XOR
   function automatic logic [7:0] crc8(input logic [191:0] d);
      logic [7:0] c;
      logic       fb;
      c = '0;
      for (int unsigned i = 0; i < 192; i++) begin
         fb = c[7] ^ d[191 - i];
         c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return c;
   endfunction

   logic          w_unused_slc;
   logic [192:0]  w_asm;
   logic [7:0]    w_crc;
   logic          w_pop;
   logic          w_push;
   logic          w_admit;
   logic          w_drop;
   logic [LW-1:0] w_level_pop;
   logic [LW-1:0] w_level_next;
   logic [CW-1:0] w_credit;
   logic [AW-1:0] w_rd_next;
   logic [192:0]  w_head_next;
   logic          w_head_valid_next;

   logic          r_s1_valid;
   logic [192:0]  r_s1_word;
   logic          r_s2_valid;
   logic [192:0]  r_s2_word;
   logic [192:0]  r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   logic [192:0]  r_out_word;
   logic          r_out_valid;
   logic [15:0]   r_drop_cnt;

   assign w_unused_slc = ^slc_fields[42:40];

   assign w_asm = {1'b1, slc_header, slc_fields[39:0], slc_cointype,
                   6'd0, 8'd0, LINK_FIBERID, LINK_SLID, COMMA,
                   mdt_fields, 49'd0};

   // crc field of r_s1_word is zero, so the CRC covers the word as-is
   assign w_crc = crc8(r_s1_word[191:0]);

   assign w_pop        = r_out_valid & mtc2sl_ready;
   assign w_push       = r_s2_valid;
   assign w_level_pop  = r_level - LW'(w_pop);
   assign w_level_next = w_level_pop + LW'(w_push);
   assign w_rd_next    = r_rd_ptr + AW'(w_pop);

   // Every word in S1/S2 already owns a FIFO slot; a pop this cycle frees one
   assign w_credit = CW'(w_level_pop) + CW'(r_s1_valid) + CW'(r_s2_valid);
   assign w_admit  = cand_valid & (w_credit < CW'(FIFO_DEPTH));
   assign w_drop   = cand_valid & ~w_admit;

   // Output register mirrors the head as it will be after this edge; when the
   // FIFO would otherwise be empty the incoming S2 word is forwarded directly.
   always_comb begin
      w_head_next       = '0;
      w_head_valid_next = 1'b0;
      if (w_level_next != '0) begin
         w_head_valid_next = 1'b1;
         if (w_level_pop == '0) begin
            w_head_next = r_s2_word;
         end else begin
            w_head_next = r_mem[w_rd_next];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_word  <= '0;
         r_s2_valid <= 1'b0;
         r_s2_word  <= '0;
      end else begin
         r_s1_valid <= w_admit;
         r_s1_word  <= w_asm;
         r_s2_valid <= r_s1_valid;
         r_s2_word  <= {r_s1_word[192:111], w_crc, r_s1_word[102:0]};
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= r_s2_word;
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_out_word  <= '0;
         r_out_valid <= 1'b0;
         r_drop_cnt  <= '0;
      end else begin
         r_wr_ptr    <= r_wr_ptr + AW'(w_push);
         r_rd_ptr    <= w_rd_next;
         r_level     <= w_level_next;
         r_out_word  <= w_head_next;
         r_out_valid <= w_head_valid_next;
         if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
         end
      end
   end

   assign mtc2sl       = r_out_word;
   assign mtc2sl_valid = r_out_valid;
   assign drop_cnt     = r_drop_cnt;
   assign fifo_level   = r_level;

endmodule

// File: tb/tb_mtc_sl_frame_builder.sv
module tb_mtc_sl_frame_builder;

   localparam logic [5:0] SLID    = 6'd5;
   localparam logic [3:0] FIBERID = 4'd2;
   localparam logic [7:0] CMA     = 8'hBC;
   localparam int         DEPTH   = 8;

   logic          clock;
   logic          rst;
   logic          cand_valid;
   logic [31:0]   slc_header;
   logic [42:0]   slc_fields;
   logic [2:0]    slc_cointype;
   logic [35:0]   mdt_fields;
   logic [192:0]  mtc2sl;
   logic          mtc2sl_valid;
   logic          mtc2sl_ready;
   logic [15:0]   drop_cnt;
   logic [3:0]    fifo_level;

   mtc_sl_frame_builder #(
      .LINK_SLID   (SLID),
      .LINK_FIBERID(FIBERID),
      .COMMA       (CMA),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clock       (clock),
      .rst         (rst),
      .cand_valid  (cand_valid),
      .slc_header  (slc_header),
      .slc_fields  (slc_fields),
      .slc_cointype(slc_cointype),
      .mdt_fields  (mdt_fields),
      .mtc2sl      (mtc2sl),
      .mtc2sl_valid(mtc2sl_valid),
      .mtc2sl_ready(mtc2sl_ready),
      .drop_cnt    (drop_cnt),
      .fifo_level  (fifo_level)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int unsigned   checks = 0;
   int unsigned   errors = 0;
   int            t = 0;
   int            occ_q[$];          // cycle at which each outstanding word becomes visible
   logic [192:0]  sb_q[$];           // expected words, in order
   logic [192:0]  got_q[$];          // words actually taken from the DUT
   logic [15:0]   drop_model = '0;
   logic [15:0]   exp_drop = '0;
   int            exp_level = 0;
   logic          exp_valid = 1'b0;

   task automatic chk(input string nm, input logic [192:0] act, input logic [192:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0d)", nm, act, exp, t);
      end
   endtask

   // CRC by polynomial long division over the message followed by 8 zero bits
   function automatic logic [7:0] crc_div(input logic [191:0] msg);
      logic [199:0] r;
      int unsigned  i;
      r = {msg, 8'h00};
      for (int unsigned k = 0; k < 192; k++) begin
         i = 199 - k;
         if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
      end
      return r[7:0];
   endfunction

   // Word built field by field by shifting in MSB first, CRC placed afterwards
   function automatic logic [192:0] model_word(input logic [31:0] h, input logic [42:0] s,
                                               input logic [2:0] ct, input logic [35:0] m);
      logic [192:0] w;
      logic [7:0]   c;
      w = 193'd1;
      w = (w << 32) | 193'(h);
      w = (w << 40) | 193'(s[39:0]);
      w = (w << 3)  | 193'(ct);
      w = w << 6;
      w = w << 8;
      w = (w << 4)  | 193'(FIBERID);
      w = (w << 6)  | 193'(SLID);
      w = (w << 8)  | 193'(CMA);
      w = (w << 36) | 193'(m);
      w = w << 49;
      c = crc_div(w[191:0]);
      w = w | (193'(c) << (4 + 6 + 8 + 36 + 49));
      return w;
   endfunction

   task automatic step(input logic cv, input logic [31:0] h, input logic [42:0] s,
                       input logic [2:0] ct, input logic [35:0] m,
                       input logic rdy, input logic rs);
      int  lvl;
      bit  pop;
      bit  admit;
      @(posedge clock);
      #1;
      t++;
      rst          = rs;
      cand_valid   = cv;
      slc_header   = h;
      slc_fields   = s;
      slc_cointype = ct;
      mdt_fields   = m;
      mtc2sl_ready = rdy;
      if (rs) begin
         occ_q.delete();
         sb_q.delete();
         drop_model = '0;
         exp_drop   = '0;
         exp_level  = 0;
         exp_valid  = 1'b0;
      end else begin
         lvl = 0;
         foreach (occ_q[k]) if (occ_q[k] <= t) lvl++;
         exp_level = lvl;
         exp_valid = (occ_q.size() > 0) && (occ_q[0] <= t);
         exp_drop  = drop_model;
         pop   = rdy && exp_valid;
         admit = cv && ((occ_q.size() - int'(pop)) < DEPTH);
         if (pop) void'(occ_q.pop_front());
         if (cv && !admit && drop_model != 16'hFFFF) drop_model = drop_model + 16'd1;
         if (admit) begin
            occ_q.push_back(t + 3);
            sb_q.push_back(model_word(h, s, ct, m));
         end
      end
   endtask

   task automatic idle(input logic rdy, input int n);
      for (int unsigned i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0, rdy, 1'b0);
   endtask

   task automatic rand_cand(input logic rdy);
      logic [31:0] h;
      logic [42:0] s;
      logic [2:0]  ct;
      logic [35:0] m;
      h  = $urandom;
      s  = 43'({$urandom, $urandom});
      ct = 3'($urandom);
      m  = 36'({$urandom, $urandom});
      step(1'b1, h, s, ct, m, rdy, 1'b0);
   endtask

   // Monitor: compares visible state every cycle and takes words on handshakes
   always @(negedge clock) begin
      if (!rst) begin
         chk("valid", 193'(mtc2sl_valid), 193'(exp_valid));
         chk("level", 193'(fifo_level), 193'(exp_level));
         chk("drop_cnt", 193'(drop_cnt), 193'(exp_drop));
         if (!mtc2sl_valid) chk("idle_word_zero", mtc2sl, '0);
         if (mtc2sl_valid && mtc2sl_ready) begin
            got_q.push_back(mtc2sl);
            if (sb_q.size() == 0) begin
               chk("unexpected_word", mtc2sl, '0);
            end else begin
               chk("word", mtc2sl, sb_q.pop_front());
            end
         end
      end
   end

   logic [192:0] wa;
   logic [192:0] wb;
   logic [42:0]  ones43;

   initial begin
      rst = 1'b1; cand_valid = 1'b0; slc_header = '0; slc_fields = '0;
      slc_cointype = '0; mdt_fields = '0; mtc2sl_ready = 1'b0;
      ones43 = '1;
      for (int unsigned i = 0; i < 3; i++) step(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
      step(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
      @(negedge clock);
      chk("rst_valid", 193'(mtc2sl_valid), '0);
      chk("rst_word", mtc2sl, '0);
      chk("rst_level", 193'(fifo_level), '0);
      chk("rst_drop", 193'(drop_cnt), '0);

      // single candidate, slcid=3
      step(1'b1, 32'hA5A5_1234, {3'b000, 3'd3, 37'h0_1234_5678}, 3'd5, 36'h9_8765_4321, 1'b1, 1'b0);
      idle(1'b1, 5);
      if (got_q.size() == 1) begin
         wa = got_q[0];
         chk("t1_datavalid", 193'(wa[192]), 193'(1'b1));
         chk("t1_slcid", 193'(wa[159:157]), 193'(3'd3));
         chk("t1_slid", 193'(wa[98:93]), 193'(SLID));
         chk("t1_fiberid", 193'(wa[102:99]), 193'(FIBERID));
         chk("t1_comma", 193'(wa[92:85]), 193'(CMA));
         chk("t1_m_reserved", 193'(wa[48:0]), '0);
      end else begin
         chk("t1_word_count", 193'(got_q.size()), 193'(1));
      end

      // fill with ready=0, one extra candidate is dropped, then drain
      for (int unsigned i = 0; i < 9; i++) rand_cand(1'b0);
      idle(1'b0, 3);
      @(negedge clock);
      chk("t2_level_full", 193'(fifo_level), 193'(DEPTH));
      chk("t2_drop_one", 193'(drop_cnt), 193'(1));
      idle(1'b1, 10);

      // full FIFO with simultaneous pop and candidate: no drop
      for (int unsigned i = 0; i < 8; i++) rand_cand(1'b0);
      idle(1'b0, 3);
      for (int unsigned i = 0; i < 12; i++) rand_cand(1'b1);
      @(negedge clock);
      chk("t3_no_new_drop", 193'(drop_cnt), 193'(1));
      idle(1'b1, 14);

      // CRC corner patterns and single-bit sensitivity
      step(1'b1, '0, '0, '0, '0, 1'b1, 1'b0);
      step(1'b1, '1, ones43, '1, '1, 1'b1, 1'b0);
      step(1'b1, '0, '0, '0, 36'h0_0000_0001, 1'b1, 1'b0);
      idle(1'b1, 6);
      if (got_q.size() >= 3) begin
         wa = got_q[got_q.size() - 3];
         wb = got_q[got_q.size() - 1];
         chk("t4_crc_flip_differs", 193'(wa[110:103] != wb[110:103]), 193'(1));
      end else begin
         chk("t4_word_count", 193'(got_q.size()), 193'(3));
      end

      // reset with 5 words queued and 2 in flight
      for (int unsigned i = 0; i < 7; i++) rand_cand(1'b0);
      step(1'b1, $urandom, '0, '0, '0, 1'b0, 1'b1);
      step(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
      @(negedge clock);
      chk("t5_valid", 193'(mtc2sl_valid), '0);
      chk("t5_word", mtc2sl, '0);
      chk("t5_level", 193'(fifo_level), '0);
      chk("t5_drop", 193'(drop_cnt), '0);
      idle(1'b1, 8);

      // randomized traffic with random backpressure
      for (int unsigned i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) < 6) rand_cand(1'($urandom_range(0, 1)));
         else idle(1'($urandom_range(0, 1)), 1);
      end
      idle(1'b1, 20);
      @(negedge clock);
      chk("scoreboard_empty", 193'(sb_q.size()), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
